vga_timing_gen: RTL and testbench

Raster timing generator for the VGA pixel path. It walks the 640x480@60 Hz raster (800x525 total) on `vga_clk` and presents `DrawX`/`DrawY`/`blank` to the background and sprite renderers. It also delays the sync pulses to line up with the renderers' registered colour outputs, and issues a once-per-frame strobe plus a divided game tick for the game-logic FSMs.

---
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480 raster timing generator with sync delay line, frame strobe and game tick
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int PIPE_DELAY  = 1,
    parameter int TICK_FRAMES = 4
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        hs_d,
    output logic        vs_d,
    output logic        frame_start,
    output logic        tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    // 11-bit bounds so a window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [15:0] TICK_LAST = 16'(TICK_FRAMES - 1);

    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        fs_next;
    logic [15:0] tick_cnt;
    logic [15:0] tick_cnt_next;

    // Next raster position and tick phase; outputs are decoded from these so
    // every registered output describes the same pixel.
    always_comb begin
        x_next        = (DrawX == H_LAST) ? 10'd0 : DrawX + 10'd1;
        y_next        = DrawY;
        tick_cnt_next = tick_cnt;
        if (DrawX == H_LAST) begin
            y_next = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
        fs_next = (x_next == 10'd0) && (y_next == 10'd0);
        if (fs_next) begin
            tick_cnt_next = (tick_cnt == TICK_LAST) ? 16'd0 : tick_cnt + 16'd1;
        end
    end

    // Raster counters and registered decodes; reset parks on the last pixel
    // of the frame before frame 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
            tick        <= 1'b0;
            tick_cnt    <= TICK_LAST;
            frame_count <= 16'hFFFF;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            blank       <= ({1'b0, x_next} < H_VIS_END) && ({1'b0, y_next} < V_VIS_END);
            hs          <= !(({1'b0, x_next} >= HS_BEG) && ({1'b0, x_next} < HS_END));
            vs          <= !(({1'b0, y_next} >= VS_BEG) && ({1'b0, y_next} < VS_END));
            frame_start <= fs_next;
            tick        <= fs_next && (tick_cnt_next == 16'd0);
            tick_cnt    <= tick_cnt_next;
            if (fs_next) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hs_d = hs;
            assign vs_d = vs;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_sr;
            logic [PIPE_DELAY-1:0] vs_sr;

            // Sync delay line matching the renderer colour latency; reset
            // flushes any partially shifted history to the inactive level.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_sr <= '1;
                    vs_sr <= '1;
                end else begin
                    hs_sr[0] <= hs;
                    vs_sr[0] <= vs;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        hs_sr[i] <= hs_sr[i-1];
                        vs_sr[i] <= vs_sr[i-1];
                    end
                end
            end

            assign hs_d = hs_sr[PIPE_DELAY-1];
            assign vs_d = vs_sr[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_def;
    int   cyc;
    int   def_base;
    int   checks;
    int   errors;

    // default timing, PIPE_DELAY=1
    logic [9:0] d_x, d_y;
    logic d_blank, d_hs, d_vs, d_hsd, d_vsd, d_fs, d_tick;
    logic [15:0] d_fc;
    // default horizontal, short vertical (8,2,2,3), PIPE_DELAY=3
    logic [9:0] v_x, v_y;
    logic v_blank, v_hs, v_vs, v_hsd, v_vsd, v_fs, v_tick;
    logic [15:0] v_fc;
    // shrunk timing, PIPE_DELAY=0
    logic [9:0] z_x, z_y;
    logic z_blank, z_hs, z_vs, z_hsd, z_vsd, z_fs, z_tick;
    logic [15:0] z_fc;
    // shrunk timing, TICK_FRAMES=3
    logic [9:0] k_x, k_y;
    logic k_blank, k_hs, k_vs, k_hsd, k_vsd, k_fs, k_tick;
    logic [15:0] k_fc;
    // 1x1 raster, TICK_FRAMES=3: one frame per cycle to reach the frame_count wrap
    logic [9:0] w_x, w_y;
    logic w_blank, w_hs, w_vs, w_hsd, w_vsd, w_fs, w_tick;
    logic [15:0] w_fc;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(rst_def), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
        .hs(d_hs), .vs(d_vs), .hs_d(d_hsd), .vs_d(d_vsd), .frame_start(d_fs),
        .tick(d_tick), .frame_count(d_fc)
    );

    vga_timing_gen #(.V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(3)) u_v (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(v_x), .DrawY(v_y), .blank(v_blank),
        .hs(v_hs), .vs(v_vs), .hs_d(v_hsd), .vs_d(v_vsd), .frame_start(v_fs),
        .tick(v_tick), .frame_count(v_fc)
    );

    vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                     .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(0)) u_z (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
        .hs(z_hs), .vs(z_vs), .hs_d(z_hsd), .vs_d(z_vsd), .frame_start(z_fs),
        .tick(z_tick), .frame_count(z_fc)
    );

    vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                     .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .TICK_FRAMES(3)) u_k (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(k_x), .DrawY(k_y), .blank(k_blank),
        .hs(k_hs), .vs(k_vs), .hs_d(k_hsd), .vs_d(k_vsd), .frame_start(k_fs),
        .tick(k_tick), .frame_count(k_fc)
    );

    vga_timing_gen #(.H_VISIBLE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
                     .V_VISIBLE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0), .TICK_FRAMES(3)) u_w (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(w_x), .DrawY(w_y), .blank(w_blank),
        .hs(w_hs), .vs(w_vs), .hs_d(w_hsd), .vs_d(w_vsd), .frame_start(w_fs),
        .tick(w_tick), .frame_count(w_fc)
    );

    function automatic logic in_win(int v, int lo, int w);
        return (v >= lo) && (v < lo + w);
    endfunction

    // expected hs for the pixel presented after edge p+1 (p<0: reset value)
    function automatic logic hs_at(int p, int ht, int lo, int w);
        if (p < 0) return 1'b1;
        return !in_win(p % ht, lo, w);
    endfunction

    function automatic logic vs_at(int p, int ht, int vt, int lo, int w);
        if (p < 0) return 1'b1;
        return !in_win((p / ht) % vt, lo, w);
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rst_def = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({d_x, d_y} !== {10'd799, 10'd524}) begin
            errors++;
            $display("FAIL reset_pos got x=%0d y=%0d want x=799 y=524", d_x, d_y);
        end
        checks++;
        if ({d_blank, d_hs, d_vs, d_hsd, d_vsd, d_fs, d_tick} !== 7'b0111100) begin
            errors++;
            $display("FAIL reset_flags got %b want 0111100", {d_blank, d_hs, d_vs, d_hsd, d_vsd, d_fs, d_tick});
        end
        checks++;
        if (d_fc !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_frame_count got %h want ffff", d_fc);
        end
        checks++;
        if ({v_hsd, v_vsd} !== 2'b11) begin
            errors++;
            $display("FAIL reset_delay3 got %b want 11", {v_hsd, v_vsd});
        end
        rst_n    = 1'b1;
        rst_def  = 1'b1;
        cyc      = 0;
        def_base = 0;
        step();
        checks++;
        if ({d_x, d_y} !== 20'd0) begin
            errors++;
            $display("FAIL first_pos got x=%0d y=%0d want 0 0", d_x, d_y);
        end
        checks++;
        if ({d_blank, d_fs, d_tick} !== 3'b111) begin
            errors++;
            $display("FAIL first_flags got %b want 111", {d_blank, d_fs, d_tick});
        end
        checks++;
        if (d_fc !== 16'd0) begin
            errors++;
            $display("FAIL first_frame_count got %h want 0000", d_fc);
        end
    endtask

    task automatic test_hdecode();
        int hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            int p = cyc - 1 - def_base;
            logic [22:0] exp;
            exp = {10'(p % 800), 10'd0, (p % 800) < 640, hs_at(p, 800, 656, 96), hs_at(p - 1, 800, 656, 96)};
            checks++;
            if ({d_x, d_y, d_blank, d_hs, d_hsd} !== exp) begin
                errors++;
                $display("FAIL hline p=%0d got x=%0d y=%0d b=%b hs=%b hs_d=%b want %h",
                         p, d_x, d_y, d_blank, d_hs, d_hsd, exp);
            end
            if (d_hs === 1'b0) hs_low++;
            step();
        end
        checks++;
        if (hs_low !== 96) begin
            errors++;
            $display("FAIL hs_width got %0d want 96", hs_low);
        end
        checks++;
        if ({d_x, d_y} !== {10'd0, 10'd1}) begin
            errors++;
            $display("FAIL line_period got x=%0d y=%0d want 0 1", d_x, d_y);
        end
    endtask

    task automatic test_vdecode();
        int vs_low = 0;
        int fs_cnt = 0;
        while (cyc - 1 < 12000) begin
            int p = cyc - 1;
            int x = p % 800;
            int y = (p / 800) % 15;
            logic [23:0] exp;
            exp = {10'(x), 10'(y), (x < 640) && (y < 8), vs_at(p, 800, 15, 10, 2),
                   hs_at(p - 3, 800, 656, 96), vs_at(p - 3, 800, 15, 10, 2)};
            checks++;
            if ({v_x, v_y, v_blank, v_vs, v_hsd, v_vsd} !== exp) begin
                errors++;
                $display("FAIL vframe p=%0d got x=%0d y=%0d b=%b vs=%b hs_d=%b vs_d=%b want %h",
                         p, v_x, v_y, v_blank, v_vs, v_hsd, v_vsd, exp);
            end
            if (v_vs === 1'b0) vs_low++;
            if (v_fs === 1'b1) fs_cnt++;
            step();
        end
        checks++;
        if (vs_low !== 1600) begin
            errors++;
            $display("FAIL vs_width got %0d want 1600", vs_low);
        end
        checks++;
        if (fs_cnt !== 0) begin
            errors++;
            $display("FAIL early_frame_start got %0d want 0", fs_cnt);
        end
        checks++;
        if ({v_fs, v_x, v_y} !== 21'h100000) begin
            errors++;
            $display("FAIL frame_period got fs=%b x=%0d y=%0d want 1 0 0", v_fs, v_x, v_y);
        end
    endtask

    task automatic test_pipe0();
        for (int i = 0; i < 35; i++) begin
            int p = cyc - 1;
            logic hs_e = hs_at(p, 7, 5, 1);
            logic vs_e = vs_at(p, 7, 5, 3, 1);
            checks++;
            if ({z_hs, z_vs, z_hsd, z_vsd} !== {hs_e, vs_e, hs_e, vs_e}) begin
                errors++;
                $display("FAIL pipe0 p=%0d got %b want %b", p, {z_hs, z_vs, z_hsd, z_vsd}, {hs_e, vs_e, hs_e, vs_e});
            end
            step();
        end
    endtask

    task automatic test_tick();
        for (int i = 0; i < 280; i++) begin
            int  p    = cyc - 1;
            int  f    = p / 35;
            logic fs_e = (p % 35) == 0;
            logic tk_e = fs_e && ((f % 3) == 0);
            checks++;
            if ({k_fs, k_tick, k_fc} !== {fs_e, tk_e, 16'(f)}) begin
                errors++;
                $display("FAIL tick p=%0d got fs=%b tick=%b fc=%0d want fs=%b tick=%b fc=%0d",
                         p, k_fs, k_tick, k_fc, fs_e, tk_e, f);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 800 && ((cyc - 1 - def_base) % 800) != 300; i++) step();
        checks++;
        if (d_x !== 10'd300) begin
            errors++;
            $display("FAIL mid_position got x=%0d want 300", d_x);
        end
        rst_def = 1'b0;
        #1;
        checks++;
        if ({d_x, d_y, d_blank, d_hs, d_vs, d_hsd, d_vsd, d_fs, d_tick, d_fc}
            !== {10'd799, 10'd524, 7'b0111100, 16'hFFFF}) begin
            errors++;
            $display("FAIL mid_reset_async got x=%0d y=%0d flags=%b fc=%h", d_x, d_y,
                     {d_blank, d_hs, d_vs, d_hsd, d_vsd, d_fs, d_tick}, d_fc);
        end
        step();
        step();
        rst_def  = 1'b1;
        def_base = cyc;
        step();
        checks++;
        if ({d_x, d_y, d_fs, d_tick, d_fc} !== {20'd0, 2'b11, 16'd0}) begin
            errors++;
            $display("FAIL mid_restart got x=%0d y=%0d fs=%b tick=%b fc=%h", d_x, d_y, d_fs, d_tick, d_fc);
        end
        while ((cyc - 1 - def_base) < 656) step();
        checks++;
        if ({d_x, d_hs, d_hsd} !== {10'd656, 2'b01}) begin
            errors++;
            $display("FAIL mid_hs_edge got x=%0d hs=%b hs_d=%b want 656 0 1", d_x, d_hs, d_hsd);
        end
    endtask

    task automatic test_wrap();
        while (cyc - 1 < 65535) step();
        for (int i = 0; i < 4; i++) begin
            int p = cyc - 1;
            logic tk_e = (p % 3) == 0;
            checks++;
            if ({w_fc, w_tick, w_fs, w_blank, w_x, w_y} !== {16'(p), tk_e, 2'b11, 20'd0}) begin
                errors++;
                $display("FAIL wrap p=%0d got fc=%h tick=%b fs=%b b=%b want fc=%h tick=%b fs=1 b=1",
                         p, w_fc, w_tick, w_fs, w_blank, 16'(p), tk_e);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hdecode();
        test_vdecode();
        test_pipe0();
        test_tick();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
